key_filter_bank: RTL
====================

KEY_FILTER_BANK -- requirements
Module: key_filter_bank

Interface
REQ-001 SHALL have parameter MCNT_DB, default 999_999, meaning debounce window in Clk cycles (20 ms at 50 MHz).
REQ-002 SHALL have parameter MCNT_HOLD, default 49_999_999, meaning cycles held in DOWN before the first auto-repeat pulse (used only under KEY_REPEAT_EN).
REQ-003 SHALL have parameter MCNT_RPT, default 9_999_999, meaning cycles between auto-repeat pulses (used only under KEY_REPEAT_EN).
REQ-004 SHALL have port Clk  input  1  the single system clock; all logic on its rising edge.
REQ-005 SHALL have port Reset_n  input  1  reset, synchronous and active-low.
REQ-006 SHALL have port Key  input  4  raw, asynchronous, active-low push-buttons (0 = pressed).
REQ-007 SHALL have port Key_flag  output  4  registered one-cycle press pulse per key, consumed by electric_clock key handling.
REQ-008 SHALL have port Key_state  output  4  registered debounced level per key (0 = pressed).

Function
REQ-009 SHALL pass each Key bit through a 2-flop synchronizer (sync2) before any use.
REQ-010 SHALL implement four identical, independent channels, each with FSM IDLE, PRESS_FILTER, DOWN, RELEASE_FILTER and a 32-bit counter.
REQ-011 IDLE: sync2=0 -> PRESS_FILTER with counter cleared; otherwise stay.
REQ-012 PRESS_FILTER: sync2=1 -> IDLE with counter cleared (bounce); else counter increments; at counter=MCNT_DB-1 -> DOWN, Key_state bit <= 0, Key_flag bit <= 1 for exactly one cycle.
REQ-013 Press latency SHALL be exactly MCNT_DB+3 rising edges from the first edge sampling Key low (held stable) to Key_flag high.
REQ-014 DOWN: sync2=1 -> RELEASE_FILTER with counter cleared; otherwise stay with no further flags (except REQ-022).
REQ-015 RELEASE_FILTER: sync2=0 -> DOWN with counter cleared; else counter increments; at counter=MCNT_DB-1 -> IDLE, Key_state bit <= 1; no release pulse.
REQ-016 Release latency SHALL be MCNT_DB+3 edges from stable high to Key_state bit = 1.
REQ-017 Simultaneous presses SHALL be filtered independently; several Key_flag bits may pulse in the same cycle.
REQ-018 A bounce shorter than MCNT_DB cycles SHALL never produce a Key_flag pulse nor change Key_state.
REQ-019 Counters SHALL never exceed MCNT_DB-1 (no wrap-around inside filter states).

Reset
REQ-020 While Reset_n=0 at a rising edge: synchronizer flops <= 1, all FSMs <= IDLE, counters <= 0, Key_state <= 4'b1111, Key_flag <= 4'b0000.
REQ-021 Reset asserted mid-filter or mid-hold SHALL abort that operation; a key still held after reset release SHALL be re-filtered from IDLE and produce one fresh pulse after MCNT_DB+3 edges.

Configuration
REQ-022 With macro KEY_REPEAT_EN defined: in DOWN the counter increments; first extra Key_flag pulse at MCNT_HOLD cycles after entering DOWN, then one pulse every MCNT_RPT cycles while held; counter restarts from 0 on every re-entry to DOWN.
REQ-023 Without KEY_REPEAT_EN: exactly one Key_flag pulse per confirmed press; MCNT_HOLD/MCNT_RPT logic SHALL be absent.

Verification (bench overrides MCNT_DB=10, MCNT_HOLD=50, MCNT_RPT=20; 20 ns Clk)
REQ-024 Reset_n=0 for 10 cycles with Key=4'b0000 -> Key_state=4'b1111, Key_flag=0 throughout; after release, single Key_flag=4'b1111 pulse 13 edges later.
REQ-025 Key=4'b0111 held 40 cycles -> Key_flag=4'b1000 for one cycle 13 edges after change, Key_state=4'b0111; after Key=4'b1111, Key_state=4'b1111 13 edges later.
REQ-026 Key[2] toggles low 5/high 3 cycles x4, then low stable -> no pulse during toggling; exactly one Key_flag=4'b0100 13 edges after final falling edge.
REQ-027 Key=4'b1001 applied in one cycle -> Key_flag=4'b0110 in a single cycle.
REQ-028 Held key with 4-cycle release glitch -> no second pulse; Key_state stays 0.
REQ-029 KEY_REPEAT_EN defined, Key[3] held 130 cycles past confirm -> pulses at DOWN+0, +50, +70, +90, +110, +130 (6 total); undefined -> 1 total.

Source files
------------

// File: rtl/key_filter_bank.sv
// Four independent push-button debouncers: 2-flop synchronizer, press/release filter FSM per key.
// Define KEY_REPEAT_EN to add auto-repeat press pulses while a key is held in DOWN.
module key_filter_bank #(
    parameter int unsigned MCNT_DB   = 999_999,
    parameter int unsigned MCNT_HOLD = 49_999_999,
    parameter int unsigned MCNT_RPT  = 9_999_999
) (
    input  logic       Clk,
    input  logic       Reset_n,
    input  logic [3:0] Key,
    output logic [3:0] Key_flag,
    output logic [3:0] Key_state
);

    typedef enum logic [1:0] {
        IDLE,
        PRESS_FILTER,
        DOWN,
        RELEASE_FILTER
    } state_t;

    localparam logic [31:0] DB_LAST = 32'(MCNT_DB - 1);

    logic [3:0]  sync1;
    logic [3:0]  sync2;
    state_t      state     [4];
    state_t      state_nxt [4];
    logic [31:0] cnt       [4];
    logic [31:0] cnt_nxt   [4];
    logic [3:0]  flag_nxt;
    logic [3:0]  level_nxt;

`ifdef KEY_REPEAT_EN
    localparam logic [31:0] HOLD_LAST = 32'(MCNT_HOLD - 1);
    localparam logic [31:0] RPT_LAST  = 32'(MCNT_RPT - 1);

    // Set once the first hold pulse has fired; selects the shorter repeat interval.
    logic [3:0] rpt;
    logic [3:0] rpt_nxt;
`endif

    always_ff @(posedge Clk) begin
        if (!Reset_n) begin
            sync1 <= '1;
            sync2 <= '1;
        end else begin
            sync1 <= Key;
            sync2 <= sync1;
        end
    end

    always_comb begin
        flag_nxt  = '0;
        level_nxt = Key_state;
`ifdef KEY_REPEAT_EN
        rpt_nxt   = rpt;
`endif
        for (int unsigned i = 0; i < 4; i++) begin
            state_nxt[i] = state[i];
            cnt_nxt[i]   = cnt[i];
            case (state[i])
                IDLE: begin
                    if (!sync2[i]) begin
                        state_nxt[i] = PRESS_FILTER;
                        cnt_nxt[i]   = '0;
                    end
                end
                PRESS_FILTER: begin
                    if (sync2[i]) begin
                        state_nxt[i] = IDLE;
                        cnt_nxt[i]   = '0;
                    end else if (cnt[i] == DB_LAST) begin
                        state_nxt[i] = DOWN;
                        cnt_nxt[i]   = '0;
                        flag_nxt[i]  = 1'b1;
                        level_nxt[i] = 1'b0;
`ifdef KEY_REPEAT_EN
                        rpt_nxt[i]   = 1'b0;
`endif
                    end else begin
                        cnt_nxt[i] = cnt[i] + 32'd1;
                    end
                end
                DOWN: begin
                    if (sync2[i]) begin
                        state_nxt[i] = RELEASE_FILTER;
                        cnt_nxt[i]   = '0;
                    end else begin
`ifdef KEY_REPEAT_EN
                        if (cnt[i] == (rpt[i] ? RPT_LAST : HOLD_LAST)) begin
                            cnt_nxt[i]  = '0;
                            flag_nxt[i] = 1'b1;
                            rpt_nxt[i]  = 1'b1;
                        end else begin
                            cnt_nxt[i] = cnt[i] + 32'd1;
                        end
`endif
                    end
                end
                RELEASE_FILTER: begin
                    if (!sync2[i]) begin
                        // Glitch on release: back to DOWN with the hold timer restarted.
                        state_nxt[i] = DOWN;
                        cnt_nxt[i]   = '0;
`ifdef KEY_REPEAT_EN
                        rpt_nxt[i]   = 1'b0;
`endif
                    end else if (cnt[i] == DB_LAST) begin
                        state_nxt[i] = IDLE;
                        cnt_nxt[i]   = '0;
                        level_nxt[i] = 1'b1;
                    end else begin
                        cnt_nxt[i] = cnt[i] + 32'd1;
                    end
                end
                default: begin
                    state_nxt[i] = IDLE;
                    cnt_nxt[i]   = '0;
                end
            endcase
        end
    end

    always_ff @(posedge Clk) begin
        if (!Reset_n) begin
            for (int unsigned i = 0; i < 4; i++) begin
                state[i] <= IDLE;
                cnt[i]   <= '0;
            end
            Key_flag  <= '0;
            Key_state <= '1;
`ifdef KEY_REPEAT_EN
            rpt       <= '0;
`endif
        end else begin
            for (int unsigned i = 0; i < 4; i++) begin
                state[i] <= state_nxt[i];
                cnt[i]   <= cnt_nxt[i];
            end
            Key_flag  <= flag_nxt;
            Key_state <= level_nxt;
`ifdef KEY_REPEAT_EN
            rpt       <= rpt_nxt;
`endif
        end
    end

endmodule
